// File: rtl/path_addr_sched_pkg.sv
// path_addr_sched_pkg: shared constants for the ORAM path-access scheduler.
//   - Parameter defaults for the PathORAM tree geometry and DRAM burst layout.
//   - FSM state encodings (legacy-compatible localparams).
//   - Grant struct shared by the top and the arbiter.
//   - log2 / power-of-two helpers and the DDRAWidth sanity check.
package path_addr_sched_pkg;

  localparam int unsigned ORAML_DEF          = 10;
  localparam int unsigned BURSTS_PER_BKT_DEF = 4;
  localparam int unsigned DDRA_WIDTH_DEF     = 28;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StIssue = 2'd2;

  typedef struct packed {
    logic wr;
    logic rd;
  } grant_t;

  // Ceil log2 that yields 0 for 1 (a single burst needs no offset bits).
  function automatic int unsigned log2_ceil(input int unsigned v);
    return (v <= 1) ? 0 : $clog2(v);
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // A burst address is {bucket index (ORAML+2 bits), burst offset}.
  function automatic bit ddra_width_ok(input int unsigned oraml, input int unsigned bursts,
                                       input int unsigned width);
    return width >= oraml + 2 + log2_ceil(bursts);
  endfunction

endpackage

// File: rtl/path_addr_sched_if.sv
// path_addr_sched_if: request, generator and DRAM-command signals of the path scheduler.
//   master: the scheduler (drives ready strobes, generator controls and commands).
//   slave : the surroundings (request sources, address generator, DRAM command sink).
interface path_addr_sched_if import path_addr_sched_pkg::*; #(
  parameter int unsigned ORAML     = ORAML_DEF,
  parameter int unsigned DDRAWidth = DDRA_WIDTH_DEF
);
  logic [ORAML-1:0]     rd_leaf;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [ORAML-1:0]     wr_leaf;
  logic                 wr_valid;
  logic                 wr_ready;
  logic                 gen_start;
  logic                 gen_enable;
  logic [ORAML-1:0]     gen_leaf;
  logic [ORAML+1:0]     gen_bkt_idx;
  logic [DDRAWidth-1:0] cmd_addr;
  logic                 cmd_write;
  logic                 cmd_last;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 busy;

  modport master (
    input  rd_leaf, rd_valid, wr_leaf, wr_valid, gen_bkt_idx, cmd_ready,
    output rd_ready, wr_ready, gen_start, gen_enable, gen_leaf,
           cmd_addr, cmd_write, cmd_last, cmd_valid, busy
  );

  modport slave (
    output rd_leaf, rd_valid, wr_leaf, wr_valid, gen_bkt_idx, cmd_ready,
    input  rd_ready, wr_ready, gen_start, gen_enable, gen_leaf,
           cmd_addr, cmd_write, cmd_last, cmd_valid, busy
  );
endinterface

// File: rtl/path_req_arb.sv
// path_req_arb: 2-way arbiter between the read-path and writeback requesters.
//   rd_valid_i/wr_valid_i : request valids
//   accept_en_i           : scheduler can accept a request this cycle
//   grant_o               : one-hot grant; rd_ready_o/wr_ready_o mirror it as ready strobes
// Build option PATH_SCHED_RR_ARB_EN: round-robin on ties (adds clk/rst_n and a
// last-grant flop); otherwise read has fixed priority and the block is purely combinational.
module path_req_arb import path_addr_sched_pkg::*; (
`ifdef PATH_SCHED_RR_ARB_EN
  input  logic   clk,
  input  logic   rst_n,
`endif
  input  logic   rd_valid_i,
  input  logic   wr_valid_i,
  input  logic   accept_en_i,
  output grant_t grant_o,
  output logic   rd_ready_o,
  output logic   wr_ready_o
);

`ifdef PATH_SCHED_RR_ARB_EN
  // 1 = write was granted last; resets to write so the first tie goes to read.
  logic last_wr_q, last_wr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_wr_q <= 1'b1;
    else        last_wr_q <= last_wr_d;
  end

  always_comb begin
    last_wr_d = last_wr_q;
    if (grant_o.rd || grant_o.wr) last_wr_d = grant_o.wr;
  end
`endif

  always_comb begin
    grant_o = '0;
    if (accept_en_i) begin
      if (rd_valid_i && wr_valid_i) begin
`ifdef PATH_SCHED_RR_ARB_EN
        grant_o.rd = last_wr_q;
        grant_o.wr = ~last_wr_q;
`else
        grant_o.rd = 1'b1;
`endif
      end else if (rd_valid_i) begin
        grant_o.rd = 1'b1;
      end else if (wr_valid_i) begin
        grant_o.wr = 1'b1;
      end
    end
  end

  assign rd_ready_o = grant_o.rd;
  assign wr_ready_o = grant_o.wr;

endmodule

// File: rtl/path_addr_sched.sv
// path_addr_sched: arbitrates read-path / writeback path requests, drives the bucket-head
// address generator (Start once, Enable once per bucket) and expands every bucket into
// BurstsPerBkt consecutive DRAM burst commands under a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset (abandons any path in flight)
//   bus        : path_addr_sched_if.master (requests, generator control, DRAM commands, busy)
// Build option PATH_SCHED_RR_ARB_EN: round-robin arbitration instead of read priority.
module path_addr_sched import path_addr_sched_pkg::*; #(
  parameter int unsigned ORAML        = ORAML_DEF,
  parameter int unsigned BurstsPerBkt = BURSTS_PER_BKT_DEF,
  parameter int unsigned DDRAWidth    = DDRA_WIDTH_DEF
) (
  input logic               clk,
  input logic               rst_n,
  path_addr_sched_if.master bus
);

  localparam int unsigned LvlW       = $clog2(ORAML) + 1;
  localparam int unsigned BurstShift = log2_ceil(BurstsPerBkt);
  localparam int unsigned BurstW     = (BurstShift == 0) ? 1 : BurstShift;
  localparam logic [LvlW-1:0]   LvlLast   = LvlW'(ORAML);
  localparam logic [BurstW-1:0] BurstLast = BurstW'(BurstsPerBkt - 1);

  if (!ddra_width_ok(ORAML, BurstsPerBkt, DDRAWidth)) begin : g_bad_ddra_width
    $error("path_addr_sched: DDRAWidth too narrow for ORAML and BurstsPerBkt");
  end
  if (!is_pow2(BurstsPerBkt)) begin : g_bad_bursts
    $error("path_addr_sched: BurstsPerBkt must be a power of two");
  end

  logic [1:0]       state_q, state_d;
  logic [LvlW-1:0]  lvl_q, lvl_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic             op_write_q, op_write_d;
  logic [ORAML-1:0] leaf_q, leaf_d;

  grant_t grant;
  logic   accept_en, is_issue, bkt_done, lvl_done, handshake;
  logic   gen_start, gen_enable;
  logic [DDRAWidth-1:0] addr;

  // Gating with rst_n keeps the ready strobes low while reset is held.
  assign accept_en = (state_q == StIdle) && rst_n;
  assign is_issue  = (state_q == StIssue);
  assign bkt_done  = (burst_q == BurstLast);
  assign lvl_done  = (lvl_q == LvlLast);
  assign handshake = is_issue && bus.cmd_ready;

  path_req_arb u_arb (
`ifdef PATH_SCHED_RR_ARB_EN
    .clk         (clk),
    .rst_n       (rst_n),
`endif
    .rd_valid_i  (bus.rd_valid),
    .wr_valid_i  (bus.wr_valid),
    .accept_en_i (accept_en),
    .grant_o     (grant),
    .rd_ready_o  (bus.rd_ready),
    .wr_ready_o  (bus.wr_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      lvl_q      <= '0;
      burst_q    <= '0;
      op_write_q <= 1'b0;
      leaf_q     <= '0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      burst_q    <= burst_d;
      op_write_q <= op_write_d;
      leaf_q     <= leaf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    burst_d    = burst_q;
    op_write_d = op_write_q;
    leaf_d     = leaf_q;
    gen_start  = 1'b0;
    gen_enable = 1'b0;
    case (state_q)
      StIdle: begin
        if (grant.rd || grant.wr) begin
          leaf_d     = grant.rd ? bus.rd_leaf : bus.wr_leaf;
          op_write_d = grant.wr;
          state_d    = StStart;
        end
      end
      StStart: begin
        gen_start = 1'b1;
        lvl_d     = '0;
        burst_d   = '0;
        state_d   = StIssue;
      end
      StIssue: begin
        if (handshake) begin
          if (!bkt_done) begin
            burst_d = burst_q + BurstW'(1);
          end else begin
            // Bucket finished: advance the generator to the next level.
            burst_d    = '0;
            gen_enable = 1'b1;
            if (lvl_done) state_d = StIdle;
            else          lvl_d   = lvl_q + LvlW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bucket head scaled to bursts, burst offset in the low bits.
  assign addr = (DDRAWidth'(bus.gen_bkt_idx) << BurstShift) | DDRAWidth'(burst_q);

  assign bus.gen_start  = gen_start;
  assign bus.gen_enable = gen_enable;
  assign bus.gen_leaf   = leaf_q;
  assign bus.cmd_valid  = is_issue;
  assign bus.cmd_write  = is_issue && op_write_q;
  assign bus.cmd_last   = is_issue && lvl_done && bkt_done;
  assign bus.cmd_addr   = is_issue ? addr : '0;
  assign bus.busy       = (state_q != StIdle);

`ifndef SYNTHESIS
  // The generator may only move its bucket index right after an Enable pulse.
  bkt_idx_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    (is_issue && $past(is_issue) && !$past(gen_enable)) |-> $stable(bus.gen_bkt_idx));
  start_enable_excl_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(gen_start && gen_enable));
`endif

endmodule

// File: tb/tb_path_addr_sched.sv
// Bench for path_addr_sched: two instances (BurstsPerBkt=4 and =1, ORAML=3) with a
// behavioural bucket-index generator (index = leaf + level) and a path-level reference model.
module tb_path_addr_sched;

  localparam int unsigned L     = 3;
  localparam int unsigned BPB_A = 4;
  localparam int unsigned DW_A  = 28;
  localparam int unsigned BPB_B = 1;
  localparam int unsigned DW_B  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  path_addr_sched_if #(.ORAML(L), .DDRAWidth(DW_A)) bus_a ();
  path_addr_sched_if #(.ORAML(L), .DDRAWidth(DW_B)) bus_b ();

  path_addr_sched #(.ORAML(L), .BurstsPerBkt(BPB_A), .DDRAWidth(DW_A)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  path_addr_sched #(.ORAML(L), .BurstsPerBkt(BPB_B), .DDRAWidth(DW_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // Address generator model: bucket head = leaf + level.
  logic [L+1:0] idx_a, idx_b;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_a <= '0;
      idx_b <= '0;
    end else begin
      if (bus_a.gen_start)       idx_a <= {2'b00, bus_a.gen_leaf};
      else if (bus_a.gen_enable) idx_a <= idx_a + 1'b1;
      if (bus_b.gen_start)       idx_b <= {2'b00, bus_b.gen_leaf};
      else if (bus_b.gen_enable) idx_b <= idx_b + 1'b1;
    end
  end
  assign bus_a.gen_bkt_idx = idx_a;
  assign bus_b.gen_bkt_idx = idx_b;

  int n_assert = 0;
  int n_fail   = 0;
  bit last_wr  = 1'b1;  // arbitration model: write counts as granted last after reset

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pick_wr(input bit rv, input bit wv);
    if (rv && wv) begin
`ifdef PATH_SCHED_RR_ARB_EN
      return !last_wr;
`else
      return 1'b0;
`endif
    end
    return wv;
  endfunction

  task automatic chk_reset_zero(input string tag);
    chk({tag, "_rd_ready"},   32'(bus_a.rd_ready),   0);
    chk({tag, "_wr_ready"},   32'(bus_a.wr_ready),   0);
    chk({tag, "_gen_start"},  32'(bus_a.gen_start),  0);
    chk({tag, "_gen_enable"}, 32'(bus_a.gen_enable), 0);
    chk({tag, "_cmd_valid"},  32'(bus_a.cmd_valid),  0);
    chk({tag, "_cmd_last"},   32'(bus_a.cmd_last),   0);
    chk({tag, "_busy"},       32'(bus_a.busy),       0);
    chk({tag, "_cmd_addr"},   32'(bus_a.cmd_addr),   0);
    chk({tag, "_gen_leaf"},   32'(bus_a.gen_leaf),   0);
  endtask

  // One full path on instance A: accept, start, then every ISSUE cycle against the model.
  task automatic run_a(input logic [L-1:0] rleaf, input logic [L-1:0] wleaf, input bit rv,
                       input bit wv, input bit hold, input int stall_pct);
    bit w;
    int lvl, b, cyc;
    logic [L-1:0] leaf;
    @(negedge clk);
    bus_a.rd_leaf   = rleaf;
    bus_a.wr_leaf   = wleaf;
    bus_a.rd_valid  = rv;
    bus_a.wr_valid  = wv;
    bus_a.cmd_ready = 1'b0;
    #1;
    w    = pick_wr(rv, wv);
    leaf = w ? wleaf : rleaf;
    chk("idle_busy", 32'(bus_a.busy), 0);
    chk("accept_rd_ready", 32'(bus_a.rd_ready), 32'(!w));
    chk("accept_wr_ready", 32'(bus_a.wr_ready), 32'(w));
    last_wr = w;
    @(negedge clk);
    if (!hold) begin
      bus_a.rd_valid = 1'b0;
      bus_a.wr_valid = 1'b0;
    end
    // Leaf changes after the accept must not reach the path.
    bus_a.rd_leaf = L'($urandom);
    bus_a.wr_leaf = L'($urandom);
    #1;
    chk("start_gen_start", 32'(bus_a.gen_start), 1);
    chk("start_gen_leaf", 32'(bus_a.gen_leaf), 32'(leaf));
    chk("start_busy", 32'(bus_a.busy), 1);
    chk("start_cmd_valid", 32'(bus_a.cmd_valid), 0);
    lvl = 0;
    b   = 0;
    cyc = 0;
    while (lvl <= int'(L)) begin
      @(negedge clk);
      bus_a.cmd_ready = ($urandom_range(99) >= stall_pct);
      #1;
      cyc++;
      if (cyc > 1000) begin
        chk("issue_timeout", 32'(cyc), 1000);
        break;
      end
      chk("cmd_valid", 32'(bus_a.cmd_valid), 1);
      chk("cmd_addr", 32'(bus_a.cmd_addr), 32'((int'(leaf) + lvl) * BPB_A + b));
      chk("cmd_write", 32'(bus_a.cmd_write), 32'(w));
      chk("cmd_last", 32'(bus_a.cmd_last), 32'(lvl == L && b == BPB_A - 1));
      chk("gen_enable", 32'(bus_a.gen_enable), 32'(bus_a.cmd_ready && b == BPB_A - 1));
      chk("issue_gen_start", 32'(bus_a.gen_start), 0);
      chk("issue_ready", 32'(bus_a.rd_ready | bus_a.wr_ready), 0);
      chk("issue_busy", 32'(bus_a.busy), 1);
      if (bus_a.cmd_ready) begin
        if (b == BPB_A - 1) begin
          b = 0;
          lvl++;
        end else begin
          b++;
        end
      end
    end
  endtask

  initial begin
    bus_a.rd_leaf = '0; bus_a.wr_leaf = '0; bus_a.wr_valid = 1'b0;
    bus_a.cmd_ready = 1'b0;
    bus_b.rd_leaf = '0; bus_b.wr_leaf = '0; bus_b.rd_valid = 1'b0; bus_b.wr_valid = 1'b0;
    bus_b.cmd_ready = 1'b1;
    // A pending request must not be acknowledged while reset is held.
    bus_a.rd_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_zero("por");
    bus_a.rd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single read, leaf 0, no stalls: addresses 0..15.
    run_a(0, 0, 1'b1, 1'b0, 1'b0, 0);
    // Backpressure on a read.
    run_a(5, 2, 1'b1, 1'b0, 1'b0, 50);
    // Write path, then three held ties (read, write, read under round-robin).
    run_a(1, 6, 1'b0, 1'b1, 1'b0, 20);
    for (int i = 0; i < 3; i++) begin
      run_a(L'($urandom), L'($urandom), 1'b1, 1'b1, 1'b1, 10);
    end
    bus_a.rd_valid = 1'b0;
    bus_a.wr_valid = 1'b0;
    // Random traffic.
    for (int i = 0; i < 6; i++) begin
      bit rv, wv;
      rv = 1'($urandom_range(1));
      wv = rv ? 1'($urandom_range(1)) : 1'b1;
      run_a(L'($urandom), L'($urandom), rv, wv, 1'b0, 30);
    end

    // Reset mid-path at level 1 burst 2.
    @(negedge clk);
    bus_a.rd_leaf   = 4;
    bus_a.rd_valid  = 1'b1;
    bus_a.cmd_ready = 1'b1;
    #1;
    chk("mid_accept", 32'(bus_a.rd_ready), 1);
    @(negedge clk);
    bus_a.rd_valid = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    chk("mid_pos_addr", 32'(bus_a.cmd_addr), 22);
    rst_n = 1'b0;
    #1;
    chk_reset_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    bus_a.cmd_ready = 1'b0;
    last_wr = 1'b1;
    run_a(0, 6, 1'b0, 1'b1, 1'b0, 0);
    @(negedge clk);
    bus_a.cmd_ready = 1'b0;
    #1;
    chk("final_idle_busy", 32'(bus_a.busy), 0);
    chk("final_idle_valid", 32'(bus_a.cmd_valid), 0);

    // Single-burst buckets: address = bucket head, Enable on every handshake.
    @(negedge clk);
    bus_b.rd_leaf  = 3;
    bus_b.rd_valid = 1'b1;
    #1;
    chk("b_accept", 32'(bus_b.rd_ready), 1);
    @(negedge clk);
    bus_b.rd_valid = 1'b0;
    #1;
    chk("b_start", 32'(bus_b.gen_start), 1);
    for (int k = 0; k <= int'(L); k++) begin
      @(negedge clk);
      #1;
      chk("b_cmd_valid", 32'(bus_b.cmd_valid), 1);
      chk("b_cmd_addr", 32'(bus_b.cmd_addr), 32'(3 + k));
      chk("b_gen_enable", 32'(bus_b.gen_enable), 1);
      chk("b_cmd_last", 32'(bus_b.cmd_last), 32'(k == L));
      chk("b_cmd_write", 32'(bus_b.cmd_write), 0);
    end
    @(negedge clk);
    #1;
    chk("b_idle_busy", 32'(bus_b.busy), 0);
    chk("b_idle_valid", 32'(bus_b.cmd_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/path_addr_sched.md
Name: path_addr_sched

Overview:
- Sequencer that arbitrates path-access requests from the ORAM read-path and writeback engines.
- For the granted request it drives the bucket-head address generator: Start once, then Enable once per bucket.
- Expands each bucket head into BurstsPerBkt consecutive DRAM burst commands with a valid/ready handshake.
- Sits between the ORAM frontend/stash controller and the DRAM command interface.

Parameters:
- ORAML, 10: tree depth. A path has ORAML+1 buckets, levels 0..ORAML.
- BurstsPerBkt, 4: DRAM bursts per bucket. Power of two, at least 1.
- DDRAWidth, 28: width of CmdAddr in burst units. Must be at least ORAML+2+log2(BurstsPerBkt); elaboration error otherwise.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- RdLeaf  in  ORAML  leaf label for the read-path request.
- RdValid  in  1  read request valid.
- RdReady  out  1  read request accepted this cycle.
- WrLeaf  in  ORAML  leaf label for the writeback request.
- WrValid  in  1  writeback request valid.
- WrReady  out  1  writeback request accepted this cycle.
- GenStart  out  1  Start to the address generator.
- GenEnable  out  1  advance the address generator one level.
- GenLeaf  out  ORAML  leaf presented with GenStart.
- GenBktIdx  in  ORAML+2  current bucket head index from the generator.
- CmdAddr  out  DDRAWidth  burst address.
- CmdWrite  out  1  1 = writeback path, 0 = read path.
- CmdLast  out  1  last burst of the path.
- CmdValid  out  1  command valid.
- CmdReady  in  1  downstream accepts the command.
- Busy  out  1  state is not IDLE.

Behaviour:
- Reset (async assert, any state): state=IDLE, lvlCnt=0, burstCnt=0, opWrite=0, leafReg=0.
  - All outputs are 0 during and after reset: RdReady, WrReady, GenStart, GenEnable, CmdValid, CmdLast, Busy, CmdAddr, GenLeaf.
  - A path in flight is abandoned. No partial-path completion after reset deasserts.
- IDLE:
  - If RdValid or WrValid is asserted, grant one requester and raise that requester's Ready combinationally for exactly that cycle.
  - Latch its leaf into leafReg and the operation into opWrite, then go to START.
  - Default arbitration is fixed priority: read wins when both are valid.
  - The Ready outputs are 0 in every other state.
- START (1 cycle): GenStart=1, GenLeaf=leafReg. lvlCnt<=0, burstCnt<=0. Next state is ISSUE.
- ISSUE:
  - CmdValid=1, CmdWrite=opWrite.
  - CmdAddr = GenBktIdx*BurstsPerBkt + burstCnt, zero-extended to DDRAWidth.
  - CmdLast = (lvlCnt==ORAML) && (burstCnt==BurstsPerBkt-1).
  - Handshake occurs when CmdValid && CmdReady:
    - If burstCnt != BurstsPerBkt-1: burstCnt++.
    - Else: burstCnt<=0 and GenEnable=1 combinationally in the handshake cycle.
    - Then, if lvlCnt==ORAML, go to IDLE; else lvlCnt++.
  - Without a handshake, CmdAddr, CmdWrite and CmdLast hold stable and GenEnable=0. Downstream may stall indefinitely.
- GenLeaf = leafReg in every state; GenStart and GenEnable are never asserted together.
- Timing and counts:
  - Latency from request accept (IDLE) to first CmdValid is 2 cycles.
  - With CmdReady held at 1, a path takes (ORAML+1)*BurstsPerBkt ISSUE cycles.
  - The earliest next accept is the cycle after the last handshake; no back-to-back overlap.
  - A requester holding Valid across a path is served once per accept. Leaf changes while not Ready are ignored.
- Widths: lvlCnt is log2(ORAML)+1 bits; burstCnt is log2(BurstsPerBkt) bits, or 1 bit when BurstsPerBkt=1.
- Simulation assertion: GenBktIdx must not change in ISSUE except in the cycle following GenEnable.

Optional Feature:
- Macro: PATH_SCHED_RR_ARB_EN.
- Defined: round-robin arbitration between the two requesters.
  - A 1-bit lastGrant register resets to "write", so the first tie grants read.
  - On a tie, grant the requester not granted last.
  - lastGrant updates on every accept.
- Undefined: fixed read priority; no lastGrant register.

Decomposition:
- Shared package/header (alongside the PathORAM constants):
  - state encodings IDLE=0, START=1, ISSUE=2;
  - log2 macro; the BurstsPerBkt default;
  - a DDRAWidth sanity-check localparam.
- One natural sub-module: path_req_arb, the 2-way arbiter (fixed or round-robin).
  - Inputs: RdValid, WrValid, an accept enable (state==IDLE).
  - Outputs: grant one-hot; Ready strobes.

Test Plan:
- Single read, leaf=0, ORAML=3, BurstsPerBkt=4, GenBktIdx model = level, CmdReady=1:
  - expect 16 commands with CmdAddr 0..15 and CmdWrite=0;
  - CmdLast only on the 16th;
  - 4 GenEnable pulses; first CmdValid 2 cycles after RdReady.
- Backpressure: CmdReady toggles 1,0,0,1 while in ISSUE.
  - CmdAddr holds during stalls; burstCnt advances only on handshake; GenEnable only on a burst-3 handshake.
- Simultaneous RdValid=WrValid=1 held for 3 paths:
  - default build: RdReady granted each time;
  - with PATH_SCHED_RR_ARB_EN: grants go read, write, read.
- Reset asserted low mid-path (level 1, burst 2):
  - all outputs go 0 immediately; Busy=0;
  - after release, a new WrValid starts at level 0 burst 0 with CmdWrite=1.
- BurstsPerBkt=1, ORAML=3:
  - exactly 4 commands; GenEnable on every handshake;
  - CmdAddr equals the GenBktIdx sequence;
  - CmdLast on the 4th.
- Back-to-back requests:
  - the next RdReady occurs no earlier than the cycle after the CmdLast handshake;
  - Busy=1 from START through the last handshake.
